hazard_stall_ctrl: RTL and testbench

- Hazard/stall controller in the ID stage of the 5-stage pipeline.
- Drives Mux_Write, the select for the control-zeroing mux that inserts ID/EX bubbles, plus PC and IF/ID write enables, IF/ID flush and a whole-pipe freeze.
- Detects load-use hazards and holds multi-cycle stalls with a small FSM and counter.
- Squashes wrong-path instructions on taken branches and freezes the pipe while data memory is busy.

---
 rtl/hazard_stall_ctrl_pkg.sv | 30 +++
 rtl/hazard_stall_ctrl_load_use_detect.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the ID-stage hazard/stall controller: FSM states, control bundle
// and the RUN-state default control values.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic mux_write;
        logic if_id_flush;
        logic freeze;
    } ctrl_t;

    function automatic ctrl_t run_ctrl();
        ctrl_t c;
        c.pc_write    = 1'b1;
        c.if_id_write = 1'b1;
        c.mux_write   = 1'b1;
        c.if_id_flush = 1'b0;
        c.freeze      = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator; also shared with the forwarding-unit checks.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_mem_read,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_uses_rs2,
    output logic                  o_lu
);

    logic w_rd_nz;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired zero, so a load targeting it can never produce a hazard
    assign w_rd_nz   = (i_rd != REG_ADDR_W'(REG_ZERO));
    assign w_rs1_hit = (i_rd == i_rs1);
    assign w_rs2_hit = i_uses_rs2 & (i_rd == i_rs2);
    assign o_lu      = i_mem_read & w_rd_nz & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller with Mealy outputs (bubble the instruction in ID this cycle).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W             = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic                  IF_ID_uses_rs2,
    input  logic                  Branch_Taken,
    input  logic                  Mem_Busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
`endif
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  Mux_Write,
    output logic                  IF_ID_Flush,
    output logic                  Freeze
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_e     r_state, w_next_state;
    logic [1:0] r_cnt, w_next_cnt;
    logic       w_lu;
    ctrl_t      w_ctrl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .i_mem_read (ID_EX_MemRead),
        .i_rd       (ID_EX_rd),
        .i_rs1      (IF_ID_rs1),
        .i_rs2      (IF_ID_rs2),
        .i_uses_rs2 (IF_ID_uses_rs2),
        .o_lu       (w_lu)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Mem_Busy holds everything: EX contents are frozen, so branch/lu are re-seen later
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (Mem_Busy) begin
            w_next_state = r_state;
        end else if (Branch_Taken) begin
            w_next_state = RUN;
            w_next_cnt   = 2'd0;
        end else if (r_state == LU_STALL) begin
            w_next_cnt = r_cnt - 2'd1;
            if (r_cnt == 2'd1) w_next_state = RUN;
        end else if (w_lu && (LOAD_STALL_CYCLES > 1)) begin
            w_next_state = LU_STALL;
            w_next_cnt   = STALL_INIT;
        end
    end

    always_comb begin
        w_ctrl = run_ctrl();
        if (!reset_n) begin
            w_ctrl = '0;
        end else if (Mem_Busy) begin
            w_ctrl.freeze      = 1'b1;
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
        end else if (Branch_Taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.mux_write   = 1'b0;
        end else if ((r_state == LU_STALL) || w_lu) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
            w_ctrl.mux_write   = 1'b0;
        end
    end

    assign PCWrite     = w_ctrl.pc_write;
    assign IF_ID_Write = w_ctrl.if_id_write;
    assign Mux_Write   = w_ctrl.mux_write;
    assign IF_ID_Flush = w_ctrl.if_id_flush;
    assign Freeze      = w_ctrl.freeze;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (!w_ctrl.freeze) begin
            if (!w_ctrl.mux_write && !Branch_Taken && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_ctrl.if_id_flush && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: two controllers (1 and 3 bubbles per load-use) driven in parallel,
// compared against a remaining-bubble reference model, a vector table and hand sequences.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mr, u2, br, busy;
    logic [4:0] rd, rs1, rs2;
    logic [4:0] o1, o3;
    logic [4:0] s1, s3;

    int checks = 0;
    int errors = 0;
    int rem [2];
    int lsc [2] = '{1, 3};

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] sc1, fe1, sc3, fe3;
`endif

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ID_EX_MemRead(mr), .ID_EX_rd(rd),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_uses_rs2(u2),
        .Branch_Taken(br), .Mem_Busy(busy),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc1), .flush_events(fe1),
`endif
        .PCWrite(o1[4]), .IF_ID_Write(o1[3]), .Mux_Write(o1[2]),
        .IF_ID_Flush(o1[1]), .Freeze(o1[0])
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ID_EX_MemRead(mr), .ID_EX_rd(rd),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_uses_rs2(u2),
        .Branch_Taken(br), .Mem_Busy(busy),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc3), .flush_events(fe3),
`endif
        .PCWrite(o3[4]), .IF_ID_Write(o3[3]), .Mux_Write(o3[2]),
        .IF_ID_Flush(o3[1]), .Freeze(o3[0])
    );

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc,ifid,mux,flush,freeze)", name, act, exp);
        end
    endtask

    // Expected {PCWrite, IF_ID_Write, Mux_Write, IF_ID_Flush, Freeze} from the priority rules
    function automatic logic [4:0] model(input int idx);
        bit lu;
        lu = mr && (rd != 0) && ((rd == rs1) || (u2 && rd == rs2));
        if (busy)                  return 5'b00101;
        if (br)                    return 5'b11010;
        if (rem[idx] > 0 || lu)    return 5'b00000;
        return 5'b11100;
    endfunction

    task automatic model_advance();
        bit lu;
        lu = mr && (rd != 0) && ((rd == rs1) || (u2 && rd == rs2));
        for (int k = 0; k < 2; k++) begin
            if (busy)             rem[k] = rem[k];
            else if (br)          rem[k] = 0;
            else if (rem[k] > 0)  rem[k] = rem[k] - 1;
            else if (lu)          rem[k] = lsc[k] - 1;
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already applied
    task automatic cyc(input string name);
        logic [4:0] e1, e3;
        #3;
        e1 = model(0);
        e3 = model(1);
        s1 = o1;
        s3 = o3;
        chk({name, "/lsc1"}, s1, e1);
        chk({name, "/lsc3"}, s3, e3);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] a,
                          input logic [4:0] b, input logic u, input logic t, input logic y);
        mr = m; rd = d; rs1 = a; rs2 = b; u2 = u; br = t; busy = y;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0);
            cyc("idle");
        end
    endtask

    typedef struct {
        logic       m;
        logic [4:0] d, a, b;
        logic       u, t, y;
        logic [4:0] exp1;
        string      name;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 5, 5, 0, 0, 0, 0, 5'b00000, "lu_rs1"};
        tbl[1] = '{0, 5, 5, 0, 0, 0, 0, 5'b11100, "lu_clear"};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 5'b11100, "x0_no_haz"};
        tbl[3] = '{1, 7, 1, 7, 0, 0, 0, 5'b11100, "rs2_unused"};
        tbl[4] = '{1, 7, 1, 7, 1, 0, 0, 5'b00000, "rs2_used"};
        tbl[5] = '{0, 0, 0, 0, 0, 1, 0, 5'b11010, "branch"};
        tbl[6] = '{1, 5, 5, 0, 0, 1, 1, 5'b00101, "busy_wins"};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 5'b11100, "after_busy"};

        rem[0] = 0; rem[1] = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        chk("reset_lsc1", o1, 5'b00000);
        chk("reset_lsc3", o3, 5'b00000);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Vector table (lsc1 additionally checked against the table constants)
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].u, tbl[i].t, tbl[i].y);
            cyc(tbl[i].name);
            chk({tbl[i].name, "/tbl"}, s1, tbl[i].exp1);
        end
        idle(3);

        // Three bubbles for lsc3, then RUN
        set_in(1, 9, 9, 0, 0, 0, 0); cyc("seqA0"); chk("seqA0_mux3", s3, 5'b00000);
        set_in(0, 0, 0, 0, 0, 0, 0); cyc("seqA1"); chk("seqA1_mux3", s3, 5'b00000);
        cyc("seqA2"); chk("seqA2_mux3", s3, 5'b00000);
        cyc("seqA3"); chk("seqA3_run3", s3, 5'b11100);

        // Branch aborts a pending stall
        set_in(1, 9, 9, 0, 0, 0, 0); cyc("seqB0");
        set_in(0, 0, 0, 0, 0, 1, 0); cyc("seqB1"); chk("seqB1_flush3", s3, 5'b11010);
        set_in(0, 0, 0, 0, 0, 0, 0); cyc("seqB2"); chk("seqB2_run3", s3, 5'b11100);

        // Mem_Busy masks lu and branch for 4 cycles, then the branch applies
        for (int i = 0; i < 4; i++) begin
            set_in(1, 4, 4, 0, 0, 1, 1); cyc("seqC_busy"); chk("seqC_freeze3", s3, 5'b00101);
        end
        set_in(1, 4, 4, 0, 0, 1, 0); cyc("seqC_rel"); chk("seqC_flush3", s3, 5'b11010);
        idle(2);

        // Reset in the middle of a stall
        set_in(1, 9, 9, 0, 0, 0, 0); cyc("seqD0");
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_lsc3", o3, 5'b00000);
        chk("midreset_lsc1", o1, 5'b00000);
        rem[0] = 0; rem[1] = 0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        cyc("seqD_post"); chk("seqD_run3", s3, 5'b11100);

`ifdef HAZARD_PERF_CNT_EN
        reset_n = 1'b0; #2 reset_n = 1'b1;
        @(posedge clk); #1;
        set_in(1, 9, 9, 0, 0, 0, 0); cyc("perf0");
        set_in(0, 0, 0, 0, 0, 0, 0); cyc("perf1"); cyc("perf2");
        set_in(0, 0, 0, 0, 0, 1, 0); cyc("perf3");
        set_in(0, 0, 0, 0, 0, 0, 0); cyc("perf4");
        checks++;
        if (sc3 !== 16'd3 || fe3 !== 16'd1) begin
            errors++;
            $display("FAIL perf_cnt: got stall=%0d flush=%0d expected 3/1", sc3, fe3);
        end
        reset_n = 1'b0; #1;
        checks++;
        if (sc3 !== 16'd0 || fe3 !== 16'd0) begin
            errors++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d expected 0/0", sc3, fe3);
        end
        rem[0] = 0; rem[1] = 0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
`endif

        // Randomised traffic with a small register space to force collisions
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
